led_regs_axil: RTL
==================

LED_REGS_AXIL -- requirements
Module: led_regs_axil

Interface
REQ-001 Parameter ID_VALUE, default 32'h4C45_4430, constant returned at offset 0xC.
REQ-002 Parameter ADDR_W, default 4, byte-address width; bits [3:2] decode, all other bits ignored.
REQ-003 CLK  input  1  single clock; all logic on rising edge.
REQ-004 RSTn  input  1  reset, synchronous, active-low.
REQ-005 s_awaddr  input  ADDR_W  write address.
REQ-006 s_awvalid / s_awready  input / output  1  write-address handshake.
REQ-007 s_wdata  input  32  write data.
REQ-008 s_wstrb  input  4  byte strobes.
REQ-009 s_wvalid / s_wready  input / output  1  write-data handshake.
REQ-010 s_bresp  output  2  write response.
REQ-011 s_bvalid / s_bready  output / input  1  write-response handshake.
REQ-012 s_araddr  input  ADDR_W  read address.
REQ-013 s_arvalid / s_arready  input / output  1  read-address handshake.
REQ-014 s_rdata  output  32  read data.
REQ-015 s_rresp  output  2  read response, always 2'b00.
REQ-016 s_rvalid / s_rready  output / input  1  read-data handshake.
REQ-017 slv_reg0  input  32  status word from the LED block, readable at 0x0.
REQ-018 slv_reg1  output  32  control register, offset 0x4, drives the LED block.
REQ-019 slv_reg2  output  32  control register, offset 0x8, drives the LED block.

Function
REQ-020 Map: 0x0 slv_reg0 (RO), 0x4 slv_reg1 (RW), 0x8 slv_reg2 (RW), 0xC ID_VALUE (RO).
REQ-021 Write FSM states: WR_IDLE and WR_RESP.
REQ-022 In WR_IDLE, s_awready = 1 until an address is latched and s_wready = 1 until data is latched; AW and W are accepted in either order or in the same cycle.
REQ-023 When both address and data are held, the register updates on that edge and the FSM enters WR_RESP; s_bvalid = 1 starting the next cycle.
REQ-024 In WR_RESP, s_awready = s_wready = 0; s_bvalid and s_bresp hold until s_bvalid & s_bready, then return to WR_IDLE with both latches cleared.
REQ-025 Writes to 0x4/0x8 give s_bresp = 2'b00; writes to 0x0/0xC change nothing and give s_bresp = 2'b10.
REQ-026 Read FSM states: RD_IDLE (s_arready = 1) and RD_DATA (s_arready = 0, s_rvalid = 1).
REQ-027 On s_arvalid & s_arready, s_rdata is registered from the addressed source (slv_reg0 sampled that cycle) and RD_DATA is entered; read latency 1 cycle.
REQ-028 s_rdata and s_rvalid hold until s_rvalid & s_rready, then RD_IDLE.
REQ-029 Read and write paths are independent; a read captured on the same edge as a write to that register returns the pre-write value.
REQ-030 slv_reg1/slv_reg2 change only on an accepted write.

Reset
REQ-031 On RSTn = 0 at a clock edge: slv_reg1 = slv_reg2 = 0, s_rdata = 0, s_bresp = 0, s_bvalid = s_rvalid = 0, s_awready = s_wready = s_arready = 0, both FSMs to idle, latched AW/W discarded.
REQ-032 Ready outputs assert the first cycle after RSTn returns high; a transaction in flight at reset is dropped without response.

Configuration
REQ-033 Macro LED_REGS_WSTRB_EN: when defined, only bytes with s_wstrb[i] = 1 are written; when undefined, s_wstrb is ignored and the full 32-bit word is written.

Verification
REQ-034 Reset then idle -> slv_reg1 = slv_reg2 = 0, all valids 0, readies 1 one cycle after RSTn high.
REQ-035 AW then W three cycles later to 0x8, data 32'h0000_FFFF, strobe 4'hF -> slv_reg2 = 32'h0000_FFFF, s_bvalid next cycle, bresp 2'b00.
REQ-036 Write 32'hC100_0000 to 0x8 with s_bready held low 5 cycles -> s_bvalid stays 1, no new AW/W accepted until handshake.
REQ-037 slv_reg0 = 32'h0000_0002, read 0x0 then 0xC -> s_rdata 32'h0000_0002 then 32'h4C45_4430, each 1 cycle after AR handshake.
REQ-038 With LED_REGS_WSTRB_EN, slv_reg1 = 0, write 32'hFFFF_FFFF strobe 4'b0001 to 0x4 -> slv_reg1 = 32'h0000_00FF; without macro -> 32'hFFFF_FFFF.
REQ-039 Write 32'h1 to 0x0 -> bresp 2'b10, slv_reg1/slv_reg2 unchanged; RSTn low during WR_RESP -> bvalid 0 next cycle.

Source files
------------

// File: rtl/led_regs_axil.sv
// AXI4-Lite register slave for the LED block: status in, two control words out, ID word.
// Define LED_REGS_WSTRB_EN to honour s_wstrb byte lanes; otherwise every write is a full word.
module led_regs_axil #(
  parameter logic [31:0] ID_VALUE = 32'h4C45_4430,
  parameter int          ADDR_W   = 4
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  input  logic [31:0]       slv_reg0,
  output logic [31:0]       slv_reg1,
  output logic [31:0]       slv_reg2
);

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  wr_state_t   wr_state_reg, wr_state_next;
  rd_state_t   rd_state_reg, rd_state_next;
  logic        aw_held_reg, aw_held_next;
  logic        w_held_reg, w_held_next;
  logic [1:0]  awsel_reg, awsel_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  wstrb_reg, wstrb_next;
  logic        awready_reg, awready_next;
  logic        wready_reg, wready_next;
  logic        bvalid_reg, bvalid_next;
  logic [1:0]  bresp_reg, bresp_next;
  logic        arready_reg, arready_next;
  logic        rvalid_reg, rvalid_next;
  logic [31:0] rdata_reg, rdata_next;
  logic [31:0] slv_reg1_reg, slv_reg1_next;
  logic [31:0] slv_reg2_reg, slv_reg2_next;
  logic        wr_commit;
  logic        aw_fire, w_fire;
  logic [31:0] wr_mask;
  logic        unused_ok;

  assign aw_fire = s_awvalid && awready_reg;
  assign w_fire  = s_wvalid && wready_reg;

  // Only bits [3:2] of the addresses select a register.
  assign unused_ok = ^{s_awaddr, s_araddr, wstrb_reg};

  // Write channel: latch AW and W independently, commit once both are held.
  always_comb begin
    wr_state_next = wr_state_reg;
    aw_held_next  = aw_held_reg;
    w_held_next   = w_held_reg;
    awsel_next    = awsel_reg;
    wdata_next    = wdata_reg;
    wstrb_next    = wstrb_reg;
    awready_next  = awready_reg;
    wready_next   = wready_reg;
    bvalid_next   = bvalid_reg;
    bresp_next    = bresp_reg;
    wr_commit     = 1'b0;
    case (wr_state_reg)
      WR_IDLE: begin
        if (aw_fire) begin
          aw_held_next = 1'b1;
          awsel_next   = s_awaddr[3:2];
        end
        if (w_fire) begin
          w_held_next = 1'b1;
          wdata_next  = s_wdata;
          wstrb_next  = s_wstrb;
        end
        if (aw_held_next && w_held_next) begin
          wr_commit     = 1'b1;
          wr_state_next = WR_RESP;
          bvalid_next   = 1'b1;
          bresp_next    = (awsel_next == 2'd1 || awsel_next == 2'd2) ? 2'b00 : 2'b10;
          aw_held_next  = 1'b0;
          w_held_next   = 1'b0;
          awready_next  = 1'b0;
          wready_next   = 1'b0;
        end else begin
          awready_next = !aw_held_next;
          wready_next  = !w_held_next;
        end
      end
      WR_RESP: begin
        if (bvalid_reg && s_bready) begin
          wr_state_next = WR_IDLE;
          bvalid_next   = 1'b0;
          awready_next  = 1'b1;
          wready_next   = 1'b1;
        end
      end
      default: wr_state_next = WR_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_mask
`ifdef LED_REGS_WSTRB_EN
    assign wr_mask[8*gi +: 8] = {8{wstrb_next[gi]}};
`else
    assign wr_mask[8*gi +: 8] = 8'hFF;
`endif
  end

  always_comb begin
    slv_reg1_next = slv_reg1_reg;
    slv_reg2_next = slv_reg2_reg;
    if (wr_commit && awsel_next == 2'd1)
      slv_reg1_next = (slv_reg1_reg & ~wr_mask) | (wdata_next & wr_mask);
    if (wr_commit && awsel_next == 2'd2)
      slv_reg2_next = (slv_reg2_reg & ~wr_mask) | (wdata_next & wr_mask);
  end

  // Read channel: mux uses current register values, so a same-edge write is not visible.
  always_comb begin
    rd_state_next = rd_state_reg;
    arready_next  = arready_reg;
    rvalid_next   = rvalid_reg;
    rdata_next    = rdata_reg;
    case (rd_state_reg)
      RD_IDLE: begin
        arready_next = 1'b1;
        if (s_arvalid && arready_reg) begin
          case (s_araddr[3:2])
            2'd0:    rdata_next = slv_reg0;
            2'd1:    rdata_next = slv_reg1_reg;
            2'd2:    rdata_next = slv_reg2_reg;
            default: rdata_next = ID_VALUE;
          endcase
          rvalid_next   = 1'b1;
          arready_next  = 1'b0;
          rd_state_next = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rvalid_reg && s_rready) begin
          rvalid_next   = 1'b0;
          arready_next  = 1'b1;
          rd_state_next = RD_IDLE;
        end
      end
      default: rd_state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      wr_state_reg <= WR_IDLE;
      rd_state_reg <= RD_IDLE;
      aw_held_reg  <= 1'b0;
      w_held_reg   <= 1'b0;
      awsel_reg    <= 2'd0;
      wdata_reg    <= 32'd0;
      wstrb_reg    <= 4'd0;
      awready_reg  <= 1'b0;
      wready_reg   <= 1'b0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= 2'b00;
      arready_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
      rdata_reg    <= 32'd0;
      slv_reg1_reg <= 32'd0;
      slv_reg2_reg <= 32'd0;
    end else begin
      wr_state_reg <= wr_state_next;
      rd_state_reg <= rd_state_next;
      aw_held_reg  <= aw_held_next;
      w_held_reg   <= w_held_next;
      awsel_reg    <= awsel_next;
      wdata_reg    <= wdata_next;
      wstrb_reg    <= wstrb_next;
      awready_reg  <= awready_next;
      wready_reg   <= wready_next;
      bvalid_reg   <= bvalid_next;
      bresp_reg    <= bresp_next;
      arready_reg  <= arready_next;
      rvalid_reg   <= rvalid_next;
      rdata_reg    <= rdata_next;
      slv_reg1_reg <= slv_reg1_next;
      slv_reg2_reg <= slv_reg2_next;
    end
  end

  assign s_awready = awready_reg;
  assign s_wready  = wready_reg;
  assign s_bvalid  = bvalid_reg;
  assign s_bresp   = bresp_reg;
  assign s_arready = arready_reg;
  assign s_rvalid  = rvalid_reg;
  assign s_rdata   = rdata_reg;
  assign s_rresp   = 2'b00;
  assign slv_reg1  = slv_reg1_reg;
  assign slv_reg2  = slv_reg2_reg;

endmodule
